// File: rtl/ps2_kbd_port_pkg.sv
// Shared definitions for the PS/2 keyboard port: receiver state encodings,
// status word bit positions and the default frame timeout.
package ps2_kbd_port_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int RDY_BIT  = 31;
  localparam int OVF_BIT  = 30;
  localparam int FERR_BIT = 29;
  localparam int CNT_LSB  = 24;

  // 2 ms at 100 MHz
  localparam int TIMEOUT_DEFAULT = 200000;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_kbd_port_frame_rx.sv
// PS/2 frame receiver: pad synchronisers, ps2_clk filter, bit FSM and frame timeout.
// Optional odd-parity rejection when PS2_PARITY_CHECK_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for a falling edge with data low (start bit)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling the stop bit, then reporting byte or error
module ps2_frame_rx
  import ps2_kbd_port_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_d;
  logic          fall, any_edge, data_s;
  logic [TW-1:0] to_cnt;
  logic          timed_out;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          parity_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign data_s = data_sync[1];

  // Filtered clock only follows the pad after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      filt_clk_d <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall     = filt_clk_d & ~filt_clk;
  assign any_edge = filt_clk_d ^ filt_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= TW'(TIMEOUT - 1);
    end else if (any_edge || state == ST_IDLE) begin
      to_cnt <= TW'(TIMEOUT - 1);
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  assign timed_out = (to_cnt == '0) && (state != ST_IDLE) && !any_edge;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;
  assign parity_ok = odd_parity_ok(shift_q, parity_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (timed_out) begin
        state <= ST_IDLE;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift_q <= {data_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= data_s;
`endif
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!data_s || !parity_ok) rx_err   <= 1'b1;
            else                       rx_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard port: frame receiver feeding a scan-code FIFO, exposed as one
// polled 32-bit status/data word with a pop-on-read strobe and a level irq.
module ps2_kbd_port
  import ps2_kbd_port_pkg::*;
#(
  parameter int FIFO_AW  = 3,
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        clr,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       rx_byte;
  logic             rx_valid, rx_err;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
  logic             empty, full, push_ok, pop_ok;
  logic             ovf_q, ferr_q;
  logic [31:0]      status_word;

  ps2_frame_rx #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (RSTN),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[FIFO_AW], rd_ptr[FIFO_AW-1:0]});
  assign push_ok = rx_valid & ~clr & ~full;
  assign pop_ok  = rd_en & ~clr & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (rx_valid && full) ovf_q <= 1'b1;
      if (rx_err) ferr_q <= 1'b1;
    end
  end

  always_comb begin
    status_word                 = '0;
    status_word[RDY_BIT]        = ~empty;
    status_word[OVF_BIT]        = ovf_q;
    status_word[FERR_BIT]       = ferr_q;
    status_word[CNT_LSB +: 4]   = 4'(count);
    status_word[7:0]            = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      data_out <= status_word;
      irq      <= ~empty;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Self-checking bench for ps2_kbd_port: directed scenarios plus randomized
// frames, pops and flushes compared against a queue-based model every settled cycle.
module tb_ps2_kbd_port;

  localparam int HALF  = 25;
  localparam int TMO   = 200;
  localparam int DEPTH = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] data_out;
  logic        irq;

  ps2_kbd_port #(
    .FIFO_AW  (3),
    .FILT_LEN (8),
    .TIMEOUT  (TMO)
  ) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .clr      (clr),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  bit       chk_en   = 1'b0;
  bit       done     = 1'b0;
  logic [7:0] q[$];
  bit       m_ovf  = 1'b0;
  bit       m_ferr = 1'b0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    int n;
    n = q.size();
    w = '0;
    w[31] = (n != 0);
    w[30] = m_ovf;
    w[29] = m_ferr;
    w[27:24] = 4'(n);
    if (n != 0) w[7:0] = q[0];
    return w;
  endfunction

  function automatic void model_frame(logic [7:0] b, bit par_bad, bit stop);
    if (!stop) m_ferr = 1'b1;
    else if (par_bad && PAR_CHK) m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back(b);
  endfunction

  function automatic void model_clear();
    q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("word", data_out, exp_word());
      check("irq", {31'b0, irq}, {31'b0, q.size() != 0});
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(logic [7:0] b, bit par_bad, bit stop, int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(logic [7:0] b, bit par_bad, bit stop);
    chk_en = 1'b0;
    send_bits(b, par_bad, stop, 11);
    wait_cyc(10);
    model_frame(b, par_bad, stop);
    chk_en = 1'b1;
    wait_cyc(3);
  endtask

  task automatic pop();
    chk_en = 1'b0;
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    wait_cyc(3);
    chk_en = 1'b1;
    wait_cyc(2);
  endtask

  task automatic flush();
    chk_en = 1'b0;
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    model_clear();
    wait_cyc(3);
    chk_en = 1'b1;
    wait_cyc(2);
  endtask

  task automatic abort_partial(int nbits);
    chk_en = 1'b0;
    send_bits(8'h55, 1'b0, 1'b1, nbits);
    chk_en = 1'b1;
    wait_cyc(TMO + 100);
  endtask

  initial begin
    wait_cyc(3);
    RSTN = 1'b1;
    wait_cyc(3);
    check("reset_word", data_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    chk_en = 1'b1;

    frame(8'h1C, 1'b0, 1'b1);
    check("t1_word", data_out, 32'h8100_001C);
    check("t1_irq", {31'b0, irq}, 32'h1);
    pop();
    check("t1_pop", data_out, 32'h0);

    frame(8'h29, 1'b0, 1'b0);
    check("t2_stop_err", data_out, 32'h2000_0000);
    flush();
    check("t2_clr", data_out, 32'h0);

    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1);
    check("t3_full", data_out, 32'hC800_0001);
    for (int i = 1; i <= 8; i++) begin
      check("t3_head", {24'b0, data_out[7:0]}, 32'(i));
      pop();
    end
    flush();

    abort_partial(5);
    frame(8'h29, 1'b0, 1'b1);
    check("t4_timeout", data_out, 32'h8100_0029);
    pop();

    frame(8'h1C, 1'b1, 1'b1);
    check("t5_parity", data_out, PAR_CHK ? 32'h2000_0000 : 32'h8100_001C);
    flush();

    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(20);
    frame(8'h33, 1'b0, 1'b1);
    check("t6_glitch", data_out, 32'h8100_0033);
    pop();

    chk_en = 1'b0;
    send_bits(8'h77, 1'b0, 1'b1, 5);
    RSTN = 1'b0;
    wait_cyc(3);
    RSTN = 1'b1;
    model_clear();
    wait_cyc(5);
    chk_en = 1'b1;
    frame(8'h5A, 1'b0, 1'b1);
    check("t6_reset", data_out, 32'h8100_005A);

    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        frame(8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) != 0));
      end else if (r <= 7) begin
        pop();
      end else if (r == 8) begin
        flush();
      end else begin
        abort_partial($urandom_range(1, 10));
      end
    end

    chk_en = 1'b0;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(900_000);
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

endmodule
